// File: rtl/ex_mem_stage_if.sv
// EX->MEM boundary bundle.
//   master : upstream EX/downstream MEM side; drives the *_i signals, observes *_o.
//   slave  : the ex_mem_stage register; consumes *_i, drives *_o.
// Signal groups: EX handshake + ALU result/flags, instruction control,
// flush, MEM handshake + registered payload, fetch redirect.
interface ex_mem_stage_if #(parameter int XLEN = 32);
  logic            in_valid_i;
  logic            in_ready_o;
  logic [XLEN-1:0] alu_res_i;
  logic            cf_i, zf_i, vf_i, sf_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [4:0]      rd_addr_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] imm_i;
  logic            branch_i, jal_i, jalr_i;
  logic [2:0]      funct3_i;
  logic            mem_read_i, mem_write_i, reg_write_i;
  logic            flush_i;
  logic            out_ready_i;
  logic            out_valid_o;
  logic [XLEN-1:0] out_alu_res_o;
  logic [XLEN-1:0] out_rs2_o;
  logic [4:0]      out_rd_o;
  logic [XLEN-1:0] out_pc4_o;
  logic            out_mem_read_o, out_mem_write_o, out_reg_write_o;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport master (
    output in_valid_i, alu_res_i, cf_i, zf_i, vf_i, sf_i, rs2_data_i, rd_addr_i,
           pc_i, imm_i, branch_i, jal_i, jalr_i, funct3_i, mem_read_i,
           mem_write_i, reg_write_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_alu_res_o, out_rs2_o, out_rd_o, out_pc4_o,
           out_mem_read_o, out_mem_write_o, out_reg_write_o, redirect_o, redirect_pc_o
  );

  modport slave (
    input  in_valid_i, alu_res_i, cf_i, zf_i, vf_i, sf_i, rs2_data_i, rd_addr_i,
           pc_i, imm_i, branch_i, jal_i, jalr_i, funct3_i, mem_read_i,
           mem_write_i, reg_write_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, out_alu_res_o, out_rs2_o, out_rd_o, out_pc4_o,
           out_mem_read_o, out_mem_write_o, out_reg_write_o, redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready handshake, branch/jump
// resolution and a one-cycle fetch redirect pulse.
// Ports:
//   clk_i   : core clock, rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : ex_mem_stage_if.slave (EX inputs, MEM outputs, redirect)
module ex_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  ex_mem_stage_if.slave   bus
);

  typedef struct packed {
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc4;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
  } payload_t;

  payload_t        pl_q, pl_d;
  logic            vld_q;
  logic            redir_q;
  logic [XLEN-1:0] redir_pc_q;
  logic            accept, cond, taken;
  logic [XLEN-1:0] target;

  // Gated with reset so every output reads 0 while reset is held.
  assign bus.in_ready_o = rst_n_i & (~vld_q | bus.out_ready_i);
  assign accept         = bus.in_valid_i & bus.in_ready_o & ~bus.flush_i;

  // Condition evaluated on the flags of the ALU's rs1-rs2 subtraction.
  always_comb begin
    cond = 1'b0;
    case (bus.funct3_i)
      3'b000:  cond = bus.zf_i;
      3'b001:  cond = ~bus.zf_i;
      3'b100:  cond = bus.sf_i ^ bus.vf_i;
      3'b101:  cond = ~(bus.sf_i ^ bus.vf_i);
      3'b110:  cond = ~bus.cf_i;
      3'b111:  cond = bus.cf_i;
      default: cond = 1'b0;
    endcase
  end

  assign taken  = (bus.branch_i & cond) | bus.jal_i | bus.jalr_i;
  // JALR wins over JAL/branch; both adds wrap at 2^XLEN.
  assign target = bus.jalr_i ? {bus.alu_res_i[XLEN-1:1], 1'b0}
                             : bus.pc_i + bus.imm_i;

  always_comb begin
    pl_d           = '0;
    pl_d.alu_res   = bus.alu_res_i;
    pl_d.rs2       = bus.rs2_data_i;
    pl_d.rd        = bus.rd_addr_i;
    pl_d.pc4       = bus.pc_i + XLEN'(4);
    pl_d.mem_read  = bus.mem_read_i;
    pl_d.mem_write = bus.mem_write_i;
    pl_d.reg_write = bus.reg_write_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q      <= 1'b0;
      pl_q       <= '0;
      redir_q    <= 1'b0;
      redir_pc_q <= '0;
    end else if (bus.flush_i) begin
      // Kill both the held and the incoming instruction.
      vld_q   <= 1'b0;
      redir_q <= 1'b0;
    end else begin
      // Pulse only on the accept edge, independent of downstream stall.
      redir_q <= accept & taken;
      if (accept) begin
        vld_q <= 1'b1;
        pl_q  <= pl_d;
        if (taken) redir_pc_q <= target;
      end else if (bus.out_ready_i) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid_o     = vld_q;
  assign bus.out_alu_res_o   = pl_q.alu_res;
  assign bus.out_rs2_o       = pl_q.rs2;
  assign bus.out_rd_o        = pl_q.rd;
  assign bus.out_pc4_o       = pl_q.pc4;
  assign bus.out_mem_read_o  = pl_q.mem_read;
  assign bus.out_mem_write_o = pl_q.mem_write;
  assign bus.out_reg_write_o = pl_q.reg_write;
  assign bus.redirect_o      = redir_q;
  assign bus.redirect_pc_o   = redir_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  ex_mem_stage_if #(.XLEN(32)) bus();

  ex_mem_stage #(.XLEN(32)) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.in_valid_i  = 1'b0;
    bus.alu_res_i   = '0;
    bus.cf_i        = 1'b0;
    bus.zf_i        = 1'b0;
    bus.vf_i        = 1'b0;
    bus.sf_i        = 1'b0;
    bus.rs2_data_i  = '0;
    bus.rd_addr_i   = '0;
    bus.pc_i        = '0;
    bus.imm_i       = '0;
    bus.branch_i    = 1'b0;
    bus.jal_i       = 1'b0;
    bus.jalr_i      = 1'b0;
    bus.funct3_i    = '0;
    bus.mem_read_i  = 1'b0;
    bus.mem_write_i = 1'b0;
    bus.reg_write_i = 1'b0;
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({bus.out_valid_o, bus.in_ready_o, bus.redirect_o} !== 3'b000) begin
      n_fail++; $display("FAIL rst_init_ctl: got %b want 000", {bus.out_valid_o, bus.in_ready_o, bus.redirect_o});
    end
    n_checks++;
    if (bus.out_alu_res_o !== 32'h0 || bus.redirect_pc_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_init_data: got %h/%h want 0/0", bus.out_alu_res_o, bus.redirect_pc_o);
    end
    // release, accept a JAL while MEM stalls
    tick();
    rst_n = 1'b1;
    bus.in_valid_i = 1'b1; bus.alu_res_i = 32'h55; bus.jal_i = 1'b1;
    bus.pc_i = 32'h0; bus.imm_i = 32'h8; bus.reg_write_i = 1'b1;
    tick();
    n_checks++;
    if ({bus.out_valid_o, bus.redirect_o} !== 2'b11) begin
      n_fail++; $display("FAIL rst_pre_accept: got %b want 11", {bus.out_valid_o, bus.redirect_o});
    end
    clr_in();
    tick();
    // mid-stall async reset
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid_o, bus.in_ready_o, bus.redirect_o, bus.out_reg_write_o} !== 4'b0000 ||
        bus.out_alu_res_o !== 32'h0 || bus.out_pc4_o !== 32'h0 || bus.redirect_pc_o !== 32'h0) begin
      n_fail++; $display("FAIL rst_async: got v=%b r=%b rd=%b alu=%h pc4=%h rpc=%h want all 0",
        bus.out_valid_o, bus.in_ready_o, bus.redirect_o, bus.out_alu_res_o, bus.out_pc4_o, bus.redirect_pc_o);
    end
    tick();
    rst_n = 1'b1;
    bus.in_valid_i = 1'b1; bus.alu_res_i = 32'h0000_1234; bus.out_ready_i = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_alu_res_o !== 32'h0000_1234) begin
      n_fail++; $display("FAIL rst_first_accept: got v=%b alu=%h want 1/00001234", bus.out_valid_o, bus.out_alu_res_o);
    end
    clr_in(); bus.out_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_alu [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid_i = 1'b1; bus.alu_res_i = exp_alu[i]; bus.rd_addr_i = 5'(i + 1);
      bus.reg_write_i = 1'b1;
      tick();
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_alu_res_o !== exp_alu[i] || bus.out_rd_o !== 5'(i + 1)) begin
        n_fail++; $display("FAIL b2b_beat%0d: got v=%b alu=%h rd=%0d want 1/%h/%0d",
          i, bus.out_valid_o, bus.out_alu_res_o, bus.out_rd_o, exp_alu[i], i + 1);
      end
    end
    // stall with a new instruction waiting
    bus.out_ready_i = 1'b0; bus.alu_res_i = 32'hDEAD; bus.rd_addr_i = 5'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.in_ready_o !== 1'b0) begin
        n_fail++; $display("FAIL stall_ready%0d: got %b want 0", i, bus.in_ready_o);
      end
      tick();
      n_checks++;
      if (bus.out_valid_o !== 1'b1 || bus.out_alu_res_o !== 32'h44 || bus.out_rd_o !== 5'd4) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%b alu=%h rd=%0d want 1/44/4",
          i, bus.out_valid_o, bus.out_alu_res_o, bus.out_rd_o);
      end
    end
    clr_in(); bus.out_ready_i = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL drain: got %b want 0", bus.out_valid_o);
    end
  endtask

  task automatic test_branch_matrix();
    // funct3, zf, cf, sf, vf, expected taken
    logic [2:0] f3 [4] = '{3'b000, 3'b110, 3'b100, 3'b010};
    logic [3:0] fl [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b1111};
    logic       tk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid_i = 1'b1; bus.branch_i = 1'b1; bus.pc_i = 32'h100; bus.imm_i = 32'h20;
      bus.funct3_i = f3[i];
      {bus.zf_i, bus.cf_i, bus.sf_i, bus.vf_i} = fl[i];
      tick();
      n_checks++;
      if (bus.redirect_o !== tk[i] || bus.redirect_pc_o !== 32'h120) begin
        n_fail++; $display("FAIL br_case%0d: got redir=%b pc=%h want %b/00000120",
          i, bus.redirect_o, bus.redirect_pc_o, tk[i]);
      end
      clr_in(); bus.out_ready_i = 1'b1;
      tick();
      n_checks++;
      if (bus.redirect_o !== 1'b0) begin
        n_fail++; $display("FAIL br_pulse_end%0d: got %b want 0", i, bus.redirect_o);
      end
    end
  endtask

  task automatic test_jalr();
    bus.in_valid_i = 1'b1; bus.jalr_i = 1'b1; bus.alu_res_i = 32'h0000_2003;
    bus.pc_i = 32'h400; bus.imm_i = 32'h40; bus.reg_write_i = 1'b1; bus.out_ready_i = 1'b0;
    tick();
    n_checks++;
    if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h2002 || bus.out_pc4_o !== 32'h404) begin
      n_fail++; $display("FAIL jalr_target: got redir=%b pc=%h pc4=%h want 1/00002002/00000404",
        bus.redirect_o, bus.redirect_pc_o, bus.out_pc4_o);
    end
    clr_in();
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (bus.redirect_o !== 1'b0 || bus.out_valid_o !== 1'b1 || bus.out_pc4_o !== 32'h404) begin
        n_fail++; $display("FAIL jalr_stall%0d: got redir=%b v=%b pc4=%h want 0/1/00000404",
          i, bus.redirect_o, bus.out_valid_o, bus.out_pc4_o);
      end
    end
    // all three control bits set: JALR target wins
    bus.out_ready_i = 1'b1; bus.in_valid_i = 1'b1;
    bus.jalr_i = 1'b1; bus.jal_i = 1'b1; bus.branch_i = 1'b1; bus.zf_i = 1'b1;
    bus.alu_res_i = 32'h0000_3001; bus.pc_i = 32'h400; bus.imm_i = 32'h40;
    tick();
    n_checks++;
    if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h3000) begin
      n_fail++; $display("FAIL jump_priority: got redir=%b pc=%h want 1/00003000", bus.redirect_o, bus.redirect_pc_o);
    end
    clr_in(); bus.out_ready_i = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    bus.in_valid_i = 1'b1; bus.mem_write_i = 1'b1; bus.rs2_data_i = 32'hCAFE;
    bus.alu_res_i = 32'h800; bus.out_ready_i = 1'b0;
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_mem_write_o !== 1'b1 || bus.out_rs2_o !== 32'hCAFE) begin
      n_fail++; $display("FAIL flush_store_held: got v=%b w=%b rs2=%h want 1/1/0000cafe",
        bus.out_valid_o, bus.out_mem_write_o, bus.out_rs2_o);
    end
    clr_in();
    bus.in_valid_i = 1'b1; bus.branch_i = 1'b1; bus.funct3_i = 3'b000; bus.zf_i = 1'b1;
    bus.pc_i = 32'h200; bus.imm_i = 32'h10; bus.out_ready_i = 1'b1; bus.flush_i = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b0 || bus.redirect_o !== 1'b0 ||
        (bus.out_valid_o & bus.out_mem_write_o) !== 1'b0) begin
      n_fail++; $display("FAIL flush_kill: got v=%b redir=%b w=%b want 0/0/-",
        bus.out_valid_o, bus.redirect_o, bus.out_mem_write_o);
    end
    clr_in(); bus.out_ready_i = 1'b1;
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b0 || bus.redirect_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_after: got v=%b redir=%b want 0/0", bus.out_valid_o, bus.redirect_o);
    end
  endtask

  task automatic test_wrap();
    bus.out_ready_i = 1'b1; bus.in_valid_i = 1'b1; bus.jal_i = 1'b1;
    bus.pc_i = 32'hFFFF_FFF0; bus.imm_i = 32'h20; bus.reg_write_i = 1'b1;
    tick();
    n_checks++;
    if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h0000_0010 ||
        bus.out_pc4_o !== 32'hFFFF_FFF4 || bus.out_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL wrap: got redir=%b pc=%h pc4=%h v=%b want 1/00000010/fffffff4/1",
        bus.redirect_o, bus.redirect_pc_o, bus.out_pc4_o, bus.out_valid_o);
    end
    clr_in(); bus.out_ready_i = 1'b1;
    tick();
  endtask

  initial begin
    clr_in();
    test_reset();
    test_back_to_back();
    test_branch_matrix();
    test_jalr();
    test_flush();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX→MEM pipeline boundary of the RISC-V core; sits directly downstream of the ALU.
- Registers the ALU result, store data and control bits into the memory stage using a valid/ready handshake.
- Resolves conditional branches from the ALU flags (cf/zf/vf/sf), and JAL/JALR targets.
- Issues a one-cycle redirect pulse with the target PC to fetch.

Parameters:
XLEN, 32, datapath width; only 32 is supported (the ALU is fixed at 32 bits).

Ports:
clk_i  input  1  core clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
in_valid_i  input  1  EX holds a valid instruction
in_ready_o  output  1  stage can accept this cycle
alu_res_i  input  32  ALU result (c_o)
cf_i  input  1  ALU carry flag
zf_i  input  1  ALU zero flag
vf_i  input  1  ALU overflow flag
sf_i  input  1  ALU sign flag
rs2_data_i  input  32  store data
rd_addr_i  input  5  destination register
pc_i  input  32  instruction PC
imm_i  input  32  sign-extended B/J immediate
branch_i  input  1  conditional branch
jal_i  input  1  JAL
jalr_i  input  1  JALR
funct3_i  input  3  branch condition
mem_read_i  input  1  load
mem_write_i  input  1  store
reg_write_i  input  1  writes rd
flush_i  input  1  kill the in-flight and incoming instruction
out_ready_i  input  1  MEM stage can accept
out_valid_o  output  1  registered instruction valid
out_alu_res_o  output  32  registered ALU result
out_rs2_o  output  32  registered store data
out_rd_o  output  5  registered rd
out_pc4_o  output  32  registered pc_i+4, the link value
out_mem_read_o  output  1  registered load
out_mem_write_o  output  1  registered store
out_reg_write_o  output  1  registered reg write
redirect_o  output  1  one-cycle taken-branch/jump pulse
redirect_pc_o  output  32  redirect target

Behaviour:
- Reset:
  - While rst_n_i is low, all outputs are 0, immediately (asynchronous).
  - Deassertion takes effect on the next clk_i edge.
  - A reset mid-transfer discards the held instruction and any pending redirect.
- Handshake:
  - in_ready_o = ~out_valid_o | out_ready_i (combinational).
  - Accept occurs when in_valid_i & in_ready_o & ~flush_i.
  - On accept, all out_* fields load on the next edge and out_valid_o=1.
  - If out_valid_o & ~out_ready_i, every out_* field holds stable.
  - If out_ready_i=1 with no accept, out_valid_o clears to 0. Data fields may hold stale values but must be ignored.
  - Latency is 1 cycle; full throughput (one per cycle) when out_ready_i is held high.
- Flush:
  - flush_i has priority over everything else.
  - Next edge: out_valid_o=0 and redirect_o=0.
  - The incoming instruction is not accepted and produces no redirect.
  - A store or reg-write under flush never reaches MEM with out_valid_o=1.
- Branch condition (funct3), evaluated on ALU SUB flags:
  - 000 BEQ: zf
  - 001 BNE: ~zf
  - 100 BLT: sf^vf
  - 101 BGE: ~(sf^vf)
  - 110 BLTU: ~cf
  - 111 BGEU: cf
  - 010/011: not taken
- taken = (branch_i & cond) | jal_i | jalr_i.
- Target, computed with 32-bit wrap-around and no overflow trap:
  - branch/JAL: pc_i+imm_i
  - JALR: {alu_res_i[31:1],1'b0}
- Redirect:
  - redirect_o and redirect_pc_o are registered and load at the accept edge.
  - redirect_o is 1 for exactly one cycle per accepted taken instruction, even if out_ready_i stays low afterward.
  - redirect_o is 0 in every other cycle.
  - redirect_pc_o holds its last value when redirect_o=0.
  - If more than one of branch_i/jal_i/jalr_i is asserted, priority is jalr_i > jal_i > branch_i.
- out_pc4_o = pc_i+4 (wraps at 2^32).

Test Plan:
- Reset mid-stall: rst_n_i low while out_valid_o=1 → all outputs 0 immediately. First accept after release passes alu_res_i=0x0000_1234, giving out_alu_res_o=0x0000_1234 one cycle later.
- Back-to-back accepts with out_ready_i=1: 4 ADDs accepted in consecutive cycles → 4 consecutive out_valid_o beats in order. Then hold out_ready_i=0 for 3 cycles → outputs stable, in_ready_o=0.
- Branch matrix on pc_i=0x100, imm_i=0x20:
  - BEQ with zf=1 → redirect_o pulse, redirect_pc_o=0x120.
  - BLTU with cf=1 → no pulse.
  - BLT with sf=1,vf=0 → pulse.
  - funct3=010 → no pulse.
- JALR: alu_res_i=0x0000_2003, pc_i=0x400 → redirect_pc_o=0x2002, out_pc4_o=0x404, single-cycle pulse while out_ready_i=0.
- Flush coinciding with an accepted taken BEQ and a held store → next cycle out_valid_o=0, redirect_o=0, out_mem_write_o not presented as valid.
- Wrap-around: pc_i=0xFFFF_FFF0, imm_i=0x20, JAL → redirect_pc_o=0x0000_0010, out_pc4_o=0xFFFF_FFF4.
